// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: configurable pipeline-boundary register.
// Carries a payload and a valid bit between two stages. The ctrl stall
// vector selects advance, hold or bubble; flush clears the stage. A carry
// side-channel keeps multi-cycle partial results alive across self-stalls,
// and two saturating counters track bubbles and hold runs.
`timescale 1ns/1ps

module pipe_stage_reg #(
  parameter int                       PAYLOAD_W   = 64,
  parameter int                       CARRY_W     = 66,
  parameter int                       STALL_W     = 6,
  parameter int                       STAGE       = 2,
  parameter int                       CNT_W       = 16,
  parameter logic [PAYLOAD_W-1:0]     NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active-low
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CARRY_W-1:0]   carry_in,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CARRY_W-1:0]   carry_out,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     hold_run
);

  // The block reads stall[STAGE+1], so it must exist in the vector.
  generate
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be less than STALL_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic up;
  logic dn;
  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Only two bits of the stall vector matter to this boundary.
  logic unused_stall;
  assign unused_stall = ^stall;

  logic                 valid_q,      valid_d;
  logic [PAYLOAD_W-1:0] payload_q,    payload_d;
  logic [CARRY_W-1:0]   carry_q,      carry_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]     hold_run_q,   hold_run_d;

  // Next-state selection: flush > bubble > advance > hold.
  always_comb begin
    valid_d      = valid_q;
    payload_d    = payload_q;
    carry_d      = carry_q;
    bubble_cnt_d = bubble_cnt_q;
    hold_run_d   = hold_run_q;
    if (flush) begin
      // Bubble count is deliberately left alone: a flush is not a bubble.
      valid_d    = 1'b0;
      payload_d  = NOP_PAYLOAD;
      carry_d    = '0;
      hold_run_d = '0;
    end else if (up && !dn) begin
      // Upstream self-stalls: emit a NOP and latch its partial result.
      valid_d    = 1'b0;
      payload_d  = NOP_PAYLOAD;
      carry_d    = carry_in;
      hold_run_d = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (!up) begin
      // Advance; dn without up is treated as advance as well.
      valid_d    = in_valid;
      payload_d  = in_payload;
      carry_d    = '0;
      hold_run_d = '0;
    end else begin
      // Hold: contents frozen, only the run length moves.
      if (hold_run_q != CNT_MAX) begin
        hold_run_d = hold_run_q + 1'b1;
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      payload_q    <= NOP_PAYLOAD;
      carry_q      <= '0;
      bubble_cnt_q <= '0;
      hold_run_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      payload_q    <= payload_d;
      carry_q      <= carry_d;
      bubble_cnt_q <= bubble_cnt_d;
      hold_run_q   <= hold_run_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign carry_out   = carry_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign hold_run    = hold_run_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios followed by random traffic, all
// checked against a behavioural model of the boundary register.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam int PW      = 64;
  localparam int CW      = 66;
  localparam int SW      = 6;
  localparam int STG     = 2;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] stall = '0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic [CW-1:0] carry_in = '0;
  logic          out_valid;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] carry_out;
  logic [CNTW-1:0] bubble_cnt;
  logic [CNTW-1:0] hold_run;

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .CARRY_W(CW), .STALL_W(SW), .STAGE(STG), .CNT_W(CNTW),
    .NOP_PAYLOAD('0)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .carry_in(carry_in),
    .out_valid(out_valid), .out_payload(out_payload), .carry_out(carry_out),
    .bubble_cnt(bubble_cnt), .hold_run(hold_run)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic          m_valid;
  logic [PW-1:0] m_payload;
  logic [CW-1:0] m_carry;
  int            m_bubbles;
  int            m_hold;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},   128'(out_valid),   128'(m_valid));
    check({tag, ".payload"}, 128'(out_payload), 128'(m_payload));
    check({tag, ".carry"},   128'(carry_out),   128'(m_carry));
    check({tag, ".bubble"},  128'(bubble_cnt),  128'(m_bubbles));
    check({tag, ".hold"},    128'(hold_run),    128'(m_hold));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_payload = '0; m_carry = '0; m_bubbles = 0; m_hold = 0;
  endtask

  // Apply one edge worth of stimulus, update the model, check after the edge.
  task automatic step(input string tag, input logic [SW-1:0] st, input logic fl,
                      input logic iv, input logic [PW-1:0] pl, input logic [CW-1:0] ci);
    bit up, dn;
    stall = st; flush = fl; in_valid = iv; in_payload = pl; carry_in = ci;
    @(posedge clk);
    up = st[STG];
    dn = st[STG+1];
    if (fl) begin
      m_valid = 1'b0; m_payload = '0; m_carry = '0; m_hold = 0;
    end else if (up && !dn) begin
      m_valid = 1'b0; m_payload = '0; m_carry = ci; m_hold = 0;
      m_bubbles = (m_bubbles < CNT_MAX) ? m_bubbles + 1 : CNT_MAX;
    end else if (!up) begin
      m_valid = iv; m_payload = pl; m_carry = '0; m_hold = 0;
    end else begin
      m_hold = (m_hold < CNT_MAX) ? m_hold + 1 : CNT_MAX;
    end
    #1;
    check_all(tag);
  endtask

  // Pull reset low between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [CW-1:0] CARRY_K = 66'h3_0000_0000_0000_0005;

  initial begin
    logic [95:0] r96;
    logic [SW-1:0] st;
    model_reset();
    #1;
    check_all("reset0");
    @(negedge clk);
    rst = 1'b1;

    // Advance.
    step("adv", 6'b000000, 1'b0, 1'b1, 64'h1234, '0);

    // Bubble with carry, then release.
    step("bub1", 6'b000111, 1'b0, 1'b1, 64'h77, CARRY_K);
    step("bub2", 6'b000111, 1'b0, 1'b1, 64'h77, CARRY_K);
    check("bub2.cnt_const", 128'(bubble_cnt), 128'd2);
    check("bub2.carry_const", 128'(carry_out), 128'(CARRY_K));
    step("bub_rel", 6'b000000, 1'b0, 1'b1, 64'h55, CARRY_K);
    check("bub_rel.carry0", 128'(carry_out), 128'd0);

    // Hold for 5 edges.
    step("load", 6'b000000, 1'b0, 1'b1, 64'hABCD, '0);
    for (int i = 0; i < 5; i++) step("hold", 6'b001111, 1'b0, 1'b1, 64'h9999, CARRY_K);
    check("hold.run5", 128'(hold_run), 128'd5);
    check("hold.payload", 128'(out_payload), 128'hABCD);
    step("hold_exit", 6'b000000, 1'b0, 1'b0, 64'h4321, '0);

    // Flush overrides a bubble request.
    step("flush_bub", 6'b000111, 1'b1, 1'b1, 64'h1, CARRY_K);
    check("flush.cnt_kept", 128'(bubble_cnt), 128'd2);

    // dn without up still advances.
    step("dn_only", 6'b001000, 1'b0, 1'b1, 64'hBEEF, CARRY_K);

    // Saturation of bubble_cnt.
    for (int i = 0; i < 20; i++) step("sat", 6'b000111, 1'b0, 1'b0, 64'h0, CW'(i));
    check("sat.15", 128'(bubble_cnt), 128'd15);
    step("sat_after", 6'b000000, 1'b0, 1'b1, 64'h2, '0);
    check("sat.stays", 128'(bubble_cnt), 128'd15);

    // Hold run saturation.
    for (int i = 0; i < 18; i++) step("hsat", 6'b001111, 1'b0, 1'b0, 64'h0, '0);

    // Asynchronous reset with a live instruction in the register.
    step("pre_rst", 6'b000000, 1'b0, 1'b1, 64'hDEAD_BEEF, '0);
    async_reset("async_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: st = 6'b000000;
        1: st = 6'b000111;
        2: st = 6'b001111;
        default: st = SW'($urandom);
      endcase
      r96 = {$urandom, $urandom, $urandom};
      step("rnd", st, ($urandom_range(0, 7) == 0), 1'($urandom),
           {$urandom, $urandom}, r96[CW-1:0]);
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
